// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction unit:
// execute-stage instruction kinds, BHT counter encodings and the saturating update rule.
package bp_pkg;

    typedef enum logic [2:0] {
        BP_NONE = 3'd0,
        BP_BLT  = 3'd1,
        BP_BNE  = 3'd2,
        BP_BEX  = 3'd3,
        BP_JR   = 3'd4
    } bp_kind_t;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Two-bit saturating step: count up on taken, down on not-taken, clamp at both ends.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == STRONG_T) ? STRONG_T : cnt + 2'd1;
        end else begin
            nxt = (cnt == STRONG_NT) ? STRONG_NT : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One bimodal history entry: a 2-bit saturating counter that resets to weak not-taken
// and steps only when its entry is selected for update.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       upd_en_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next counter value: step when selected, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_en_i) begin
            cnt_d = sat_update(cnt_q, taken_i);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= WEAK_NT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Next-PC generator: owns the fetch PC, predicts jumps/branches in decode from a bimodal
// history table, resolves branches in execute and redirects fetch with flushes on mispredict.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter int          IDX_W    = 6,
    parameter int          TGT_W    = 27,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    output logic [PC_W-1:0]  pc,
    input  logic             dec_valid,
    input  logic             dec_is_jump,
    input  logic             dec_is_branch,
    input  logic [PC_W-1:0]  dec_pc,
    input  logic [PC_W-1:0]  dec_offset,
    input  logic [TGT_W-1:0] dec_target,
    output logic             pred_taken_d,
    input  logic             ex_valid,
    input  logic [2:0]       ex_kind,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  ex_rd,
    input  logic [PC_W-1:0]  ex_rs,
    input  logic [PC_W-1:0]  ex_offset,
    input  logic [TGT_W-1:0] ex_target,
    input  logic             ex_pred_taken,
    output logic             flush_f,
    output logic             flush_fd,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [CNT_W-1:0] mp_cnt_q;
    logic [CNT_W-1:0] mp_cnt_d;

    logic [1:0]       bht_cnt [0:DEPTH-1];
    logic [1:0]       dec_cnt;
    logic [PC_W-1:0]  dec_tgt;
    logic             dec_redirect;

    bp_kind_t         kind;
    logic             ex_is_cond;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_tgt;
    logic             ex_mispredict;
    logic             bht_upd;
    logic [IDX_W-1:0] ex_idx;

    assign kind   = bp_kind_t'(ex_kind);
    assign ex_idx = ex_pc[IDX_W-1:0];

    // History table: one saturating counter per index, written from execute.
    for (genvar g = 0; g < DEPTH; g++) begin : g_bht
        bp_sat_counter u_cnt (
            .clock    (clock),
            .reset    (reset),
            .upd_en_i (bht_upd && (ex_idx == IDX_W'(g))),
            .taken_i  (ex_taken),
            .cnt_o    (bht_cnt[g])
        );
    end

    // Decode prediction; reads the pre-update counter value (no same-cycle bypass).
    always_comb begin
        dec_cnt      = bht_cnt[dec_pc[IDX_W-1:0]];
        pred_taken_d = 1'b0;
        dec_tgt      = dec_pc + {{(PC_W-1){1'b0}}, 1'b1} + dec_offset;
        if (dec_is_jump) begin
            dec_tgt = {{(PC_W-TGT_W){dec_target[TGT_W-1]}}, dec_target};
        end else begin
            dec_tgt = dec_pc + {{(PC_W-1){1'b0}}, 1'b1} + dec_offset;
        end
        if (!reset && dec_valid) begin
            pred_taken_d = dec_is_jump | (dec_is_branch & dec_cnt[1]);
        end else begin
            pred_taken_d = 1'b0;
        end
    end

    // Execute resolution: actual direction, target and whether the prediction was wrong.
    always_comb begin
        ex_is_cond = 1'b0;
        ex_taken   = 1'b0;
        ex_tgt     = ex_pc + {{(PC_W-1){1'b0}}, 1'b1} + ex_offset;
        case (kind)
            BP_BLT: begin
                ex_is_cond = 1'b1;
                ex_taken   = $signed(ex_rd) < $signed(ex_rs);
            end
            BP_BNE: begin
                ex_is_cond = 1'b1;
                ex_taken   = ex_rd != ex_rs;
            end
            BP_BEX: begin
                ex_is_cond = 1'b1;
                ex_taken   = ex_rd != {PC_W{1'b0}};
                ex_tgt     = {{(PC_W-TGT_W){ex_target[TGT_W-1]}}, ex_target};
            end
            BP_JR: begin
                ex_taken = 1'b1;
                ex_tgt   = ex_rd;
            end
            default: begin
                ex_is_cond = 1'b0;
                ex_taken   = 1'b0;
            end
        endcase
        if (!reset && ex_valid) begin
            ex_mispredict = (kind == BP_JR) | (ex_is_cond & (ex_taken != ex_pred_taken));
            bht_upd       = ex_is_cond;
        end else begin
            ex_mispredict = 1'b0;
            bht_upd       = 1'b0;
        end
    end

    // Next-PC priority and flush generation; execute redirect overrides decode and stall.
    always_comb begin
        pc_d         = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        flush_f      = 1'b0;
        flush_fd     = 1'b0;
        dec_redirect = !stall && pred_taken_d;
        if (ex_mispredict) begin
            flush_fd = 1'b1;
            pc_d     = ex_taken ? ex_tgt : ex_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end else if (dec_redirect) begin
            flush_f = 1'b1;
            pc_d    = dec_tgt;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // Saturating mispredict count.
    always_comb begin
        if (ex_mispredict && !(&mp_cnt_q)) begin
            mp_cnt_d = mp_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mp_cnt_d = mp_cnt_q;
        end
    end

    // PC and mispredict counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC[PC_W-1:0];
            mp_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc_q     <= pc_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign pc             = pc_q;
    assign mispredict_cnt = mp_cnt_q;

endmodule
